init: RTL and testbench

- Power-up/start sequencer for the ALU datapath.
- A pulse on `on` starts a run:
  - downstream logic is held in reset (`rstsig`) for a fixed number of cycles;
  - then gated rising-phase (`reclk`) and falling-phase (`feclk`) clocks are released.
- When the datapath flags its last mux stage (`muxlast`), the clocks stop.
- Sits between the board clock/pushbutton and the ALU core.

---
 rtl/init_if.sv | 25 ++
 rtl/init.sv | 118 +++++++++++
 tb/tb_init.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/init_if.sv
// Sequencer-side signal bundle for the ALU power-up/start sequencer `init`.
// The board/controller side drives on/muxlast; the sequencer drives the gated clocks and reset.
interface init_if;
    logic on;
    logic muxlast;
    logic reclk;
    logic feclk;
    logic rstsig;

    modport master (
        output on,
        output muxlast,
        input  reclk,
        input  feclk,
        input  rstsig
    );

    modport slave (
        input  on,
        input  muxlast,
        output reclk,
        output feclk,
        output rstsig
    );
endinterface

// File: rtl/init.sv
// Power-up/start sequencer: holds the ALU in reset, then releases glitch-free gated clocks until muxlast.
// Optional macro INIT_ON_SYNC_EN adds a 2-flop synchronizer on `on` (start seen 2 cycles later).
module init #(
    parameter int unsigned RST_CYCLES = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic  clk,
    input  logic  rst,
    init_if.slave bus
);
    localparam logic [1:0] S_OFF   = 2'd0;
    localparam logic [1:0] S_RESET = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_CYCLES - 1);

    logic             on_s;
    logic             on_d_q;
    logic             start;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rstsig_q;
    logic             run_en_q;
    logic             en_p_q;
    logic             en_n_q;

`ifdef INIT_ON_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], bus.on};
        end
    end

    assign on_s = sync_q[1];
`else
    assign on_s = bus.on;
`endif

    // Rising-edge detect so a held pushbutton yields exactly one start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            on_d_q <= 1'b0;
        end else begin
            on_d_q <= on_s;
        end
    end

    assign start = on_s & ~on_d_q;

    always_comb begin
        // NOTE: defaults first so every path assigns state_d/cnt_d and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        if (start) begin
            state_d = S_RESET;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_RESET: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    if (bus.muxlast) begin
                        state_d = S_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // rstsig and run_en are decoded from next state so both are clean flop outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_OFF;
            cnt_q    <= '0;
            rstsig_q <= 1'b0;
            run_en_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rstsig_q <= (state_d == S_RESET);
            run_en_q <= (state_d == S_RUN);
        end
    end

    // Each enable changes only while its gated phase is low, so no runt pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_p_q <= 1'b0;
        end else begin
            en_p_q <= run_en_q;
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            en_n_q <= 1'b0;
        end else begin
            en_n_q <= run_en_q;
        end
    end

    assign bus.reclk  = clk & en_n_q;
    assign bus.feclk  = ~clk & en_p_q;
    assign bus.rstsig = rstsig_q;
endmodule

// File: tb/tb_init.sv
// Scoreboard bench for init: per-cycle stimulus and expected outputs are queued, then replayed and compared.
// Works with or without INIT_ON_SYNC_EN (start latency adjusts).
module tb_init;
`ifdef INIT_ON_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int RC = 4;
    localparam int S  = 1 + LAT;   // cycle whose edge enters RESET for an `on` driven in cycle 0
    localparam int R  = S + RC;    // cycle whose edge enters RUN

    typedef struct packed {
        logic on;
        logic mux;
        logic rs;
        logic ck;
    } step_t;

    logic  clk    = 1'b0;
    logic  rst    = 1'b1;
    logic  clk_en = 1'b0;
    int    checks = 0;
    int    errors = 0;
    step_t sb_q[$];

    init_if bus ();

    init #(.RST_CYCLES(RC), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic on, input logic mux, input logic rs, input logic ck);
        sb_q.push_back('{on: on, mux: mux, rs: rs, ck: ck});
    endtask

    // Replays queued cycles: inputs set 1 after the edge, outputs checked in high and low phases.
    task automatic run_sb(input string name);
        step_t e;
        int    c = 0;
        while (sb_q.size() > 0) begin
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            bus.on      = e.on;
            bus.muxlast = e.mux;
            #1;
            checks++;
            if ({bus.rstsig, bus.reclk, bus.feclk} !== {e.rs, e.ck, 1'b0}) begin
                errors++;
                $display("FAIL %s high c%0d: rstsig/reclk/feclk got %b want %b",
                         name, c, {bus.rstsig, bus.reclk, bus.feclk}, {e.rs, e.ck, 1'b0});
            end
            @(negedge clk);
            #2;
            checks++;
            if ({bus.rstsig, bus.reclk, bus.feclk} !== {e.rs, 1'b0, e.ck}) begin
                errors++;
                $display("FAIL %s low c%0d: rstsig/reclk/feclk got %b want %b",
                         name, c, {bus.rstsig, bus.reclk, bus.feclk}, {e.rs, 1'b0, e.ck});
            end
            c++;
        end
    endtask

    task automatic reset_dut();
        rst         = 1'b1;
        bus.on      = 1'b0;
        bus.muxlast = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clk_en      = 1'b0;
        rst         = 1'b1;
        bus.on      = 1'b0;
        bus.muxlast = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #3;
            bus.on      = i[0];
            bus.muxlast = i[1];
            #1;
            checks++;
            if ({bus.rstsig, bus.reclk, bus.feclk} !== 3'b000) begin
                errors++;
                $display("FAIL reset_hold step %0d: outputs got %b want 000", i,
                         {bus.rstsig, bus.reclk, bus.feclk});
            end
        end
        bus.on      = 1'b0;
        bus.muxlast = 1'b0;
        clk_en      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) push(1'b0, 1'b0, 1'b0, 1'b0);
        run_sb("reset_off");
    endtask

    task automatic test_start();
        reset_dut();
        for (int c = 0; c < R + 12; c++)
            push(c < 5, 1'b0, (c >= S) && (c < S + RC), c >= R + 1);
        run_sb("start");
    endtask

    task automatic test_stop();
        int d = R + 10;
        reset_dut();
        for (int c = 0; c < d + 6; c++)
            push(c == 0, (c == S) || (c == R + 9), (c >= S) && (c < S + RC),
                 (c >= R + 1) && (c <= d));
        run_sb("stop");
    endtask

    task automatic test_back_to_back();
        int s2 = R + 6 + LAT;
        reset_dut();
        for (int c = 0; c < s2 + RC + 12; c++)
            push((c == 0) || (c == R + 5), c == s2 - 1,
                 ((c >= S) && (c < S + RC)) || ((c >= s2) && (c < s2 + RC)),
                 ((c >= R + 1) && (c <= s2)) || (c >= s2 + RC + 1));
        run_sb("restart_run");
    endtask

    task automatic test_done_restart();
        int d  = R + 1;
        int s2 = d + 4 + LAT;
        int r2 = s2 + RC;
        reset_dut();
        for (int c = 0; c < r2 + 6; c++)
            push((c == 0) || (c == d + 3), 1'b1,
                 ((c >= S) && (c < S + RC)) || ((c >= s2) && (c < s2 + RC)),
                 (c == R + 1) || (c == r2 + 1));
        run_sb("restart_done");
    endtask

    task automatic test_midrun_reset();
        int s2 = 9 + LAT;
        reset_dut();
        for (int c = 0; c < R + 6; c++)
            push(c == 0, 1'b0, (c >= S) && (c < S + RC), c >= R + 1);
        run_sb("midrun_pre");
        @(posedge clk);
        #3;
        checks++;
        if (bus.reclk !== 1'b1) begin
            errors++;
            $display("FAIL midrun_active: reclk got %b want 1", bus.reclk);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.rstsig, bus.reclk, bus.feclk} !== 3'b000) begin
            errors++;
            $display("FAIL midrun_async: outputs got %b want 000", {bus.rstsig, bus.reclk, bus.feclk});
        end
        @(negedge clk);
        #2;
        checks++;
        if ({bus.rstsig, bus.reclk, bus.feclk} !== 3'b000) begin
            errors++;
            $display("FAIL midrun_low: outputs got %b want 000", {bus.rstsig, bus.reclk, bus.feclk});
        end
        rst = 1'b0;
        for (int c = 0; c < s2 + RC + 8; c++)
            push(c == 8, 1'b0, (c >= s2) && (c < s2 + RC), c >= s2 + RC + 1);
        run_sb("midrun_post");
    endtask

    initial begin
        bus.on      = 1'b0;
        bus.muxlast = 1'b0;
        test_reset();
        test_start();
        test_stop();
        test_back_to_back();
        test_done_restart();
        test_midrun_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
